// File: rtl/pos_rdr_pkg.sv
// Shared types and constants for the position cell reader.
package pos_rdr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_REQ,
        CNT_WAIT,
        STREAM,
        DRAIN,
        FIN
    } rdr_state_e;

    localparam int POS_COUNT_ADDR = 0;
    localparam int MEM_RD_LATENCY = 2;

    // Record layout {posz, posy, posx}
    localparam int COORD_WIDTH = 32;
    localparam int POSX_LSB    = 0;
    localparam int POSY_LSB    = 32;
    localparam int POSZ_LSB    = 64;

endpackage

// File: rtl/pos_rdr_fifo.sv
// Synchronous FIFO with occupancy output; the occupancy feeds the reader's read-credit check.
module pos_rdr_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/pos_cell_reader.sv
// Read sequencer for one position cell: fetches the count word, then streams records 1..count.
// Build option POS_RDR_COUNT_CLAMP_EN: clamp an oversize count and stream instead of aborting.
module pos_cell_reader
    import pos_rdr_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  count_err
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    rdr_state_e                state;
    logic [ADDR_WIDTH-1:0]     next_addr;
    logic                      cnt_wait_last;
    logic                      rec_rd;
    logic [MEM_RD_LATENCY-1:0] pipe_v;
    logic [ADDR_WIDTH-1:0]     pipe_addr [MEM_RD_LATENCY];

    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [FIFO_W-1:0]     fifo_head;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] cnt_eff;
    logic                  cnt_illegal;
    logic                  cnt_stream_ok;
    logic                  can_issue;
    logic                  drain_done;
    int                    credit_used;

    assign mem_wren = 1'b0;
    assign mem_data = '0;

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_illegal = (cnt_raw > MAX_COUNT);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_eff       = cnt_raw;
        cnt_stream_ok = !cnt_illegal;
`ifdef POS_RDR_COUNT_CLAMP_EN
        if (cnt_illegal) begin
            cnt_eff       = MAX_COUNT;
            cnt_stream_ok = 1'b1;
        end
`endif
    end

    // Every issued-but-unpopped record (FIFO + memory pipeline + this cycle's read) holds a slot.
    always_comb begin
        credit_used = int'(fifo_count) + $countones(pipe_v) + int'(rec_rd) - int'(pop);
        can_issue   = (credit_used < FIFO_DEPTH);
    end

    assign push       = pipe_v[MEM_RD_LATENCY-1];
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_pid    = fifo_empty ? '0 : fifo_head[FIFO_W-1 -: ADDR_WIDTH];
    assign out_data   = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign drain_done = !rec_rd && (pipe_v == '0) &&
                        (fifo_empty || (fifo_count == CNT_W'(1) && pop));

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            count_err      <= 1'b0;
            particle_count <= '0;
            next_addr      <= '0;
            mem_addr       <= '0;
            mem_rden       <= 1'b0;
            rec_rd         <= 1'b0;
            cnt_wait_last  <= 1'b0;
            pipe_v         <= '0;
            for (int i = 0; i < MEM_RD_LATENCY; i++) pipe_addr[i] <= '0;
        end else begin
            done     <= 1'b0;
            mem_rden <= 1'b0;
            rec_rd   <= 1'b0;
            pipe_v   <= {pipe_v[MEM_RD_LATENCY-2:0], rec_rd};
            pipe_addr[0] <= mem_addr;
            for (int i = 1; i < MEM_RD_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CNT_REQ;
                        busy      <= 1'b1;
                        count_err <= 1'b0;
                        mem_addr  <= ADDR_WIDTH'(POS_COUNT_ADDR);
                        mem_rden  <= 1'b1;
                    end
                end
                CNT_REQ: begin
                    state         <= CNT_WAIT;
                    cnt_wait_last <= 1'b0;
                end
                CNT_WAIT: begin
                    cnt_wait_last <= 1'b1;
                    if (cnt_wait_last) begin
                        particle_count <= cnt_eff;
                        count_err      <= cnt_illegal;
                        if (cnt_eff == '0) begin
                            // An empty cell drains trivially, keeping done at a fixed offset.
                            state <= DRAIN;
                        end else if (!cnt_stream_ok) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            mem_rden  <= 1'b1;
                            rec_rd    <= 1'b1;
                            mem_addr  <= ADDR_ONE;
                            next_addr <= ADDR_ONE + ADDR_ONE;
                            state     <= (cnt_eff == ADDR_ONE) ? DRAIN : STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (can_issue) begin
                        mem_rden  <= 1'b1;
                        rec_rd    <= 1'b1;
                        mem_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_ONE;
                        if (next_addr == particle_count) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pos_rdr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({pipe_addr[MEM_RD_LATENCY-1], mem_q}),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
